mips_controller: RTL and testbench

- Control unit of the single-cycle MIPS processor.
- Decodes the instruction opcode and funct fields, plus the ALU zero flag, into datapath control strobes and a 4-bit ALU operation select.
- Decode is combinational. All outputs are registered on the rising clock edge, so the datapath sees stable, glitch-free controls.
- Sits between the instruction memory output and the datapath mux, register-file and data-memory enables.

---
 rtl/mips_pkg.sv | 44 ++++
 rtl/mips_controller_alu_decoder.sv | 47 ++++
 rtl/mips_controller.sv | 88 ++++++++
 tb/tb_mips_controller.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the single-cycle MIPS control unit.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    AOP_ADD   = 2'b00,
    AOP_SUB   = 2'b01,
    AOP_FUNCT = 2'b10,
    AOP_IMM   = 2'b11
  } aluop_t;

  typedef struct packed {
    logic [3:0] alucontrol;
    logic       memwrite;
    logic       regwrite;
    logic       alusrc;
    logic       jump;
    logic       memtoreg;
    logic       pcsrc;
    logic       regdst;
  } ctrl_t;

endpackage

// File: rtl/mips_controller_alu_decoder.sv
// Combinational ALU select: aluop picks fixed add/sub, the funct field, or the immediate opcode.
module alu_decoder
  import mips_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  input  logic [5:0] opcode,
  output logic [3:0] alucontrol,
  output logic       funct_ok
);

  // funct_ok depends on funct alone so the main decoder can gate R-type writes without a comb loop
  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      F_ADD, F_SUB, F_AND, F_OR, F_SLT: funct_ok = 1'b1;
      default:                          funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    alucontrol = ALU_AND;
    case (aluop)
      AOP_ADD: alucontrol = ALU_ADD;
      AOP_SUB: alucontrol = ALU_SUB;
      AOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_AND;
        endcase
      end
      default: begin
        case (opcode)
          OP_ANDI: alucontrol = ALU_AND;
          OP_ORI:  alucontrol = ALU_OR;
          OP_SLTI: alucontrol = ALU_SLT;
          default: alucontrol = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// MIPS control unit: main decode plus ALU decode, all strobes registered on clk.
module mips_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [3:0] aluControl,
  output logic       memWrite,
  output logic       regWrite,
  output logic       aluSrc,
  output logic       jump,
  output logic       memtoReg,
  output logic       pcsrc,
  output logic       regdst
);

  aluop_t     aluop;
  logic [3:0] alu_sel;
  logic       funct_ok;
  logic       branch;
  ctrl_t      nxt, q;

  // j and unknown opcodes route through the immediate path, whose default is 0000
  always_comb begin
    aluop = AOP_IMM;
    case (opcode)
      OP_RTYPE:            aluop = AOP_FUNCT;
      OP_LW, OP_SW, OP_ADDI: aluop = AOP_ADD;
      OP_BEQ:              aluop = AOP_SUB;
      default:             aluop = AOP_IMM;
    endcase
  end

  alu_decoder u_alu_dec (
    .aluop      (aluop),
    .funct      (funct),
    .opcode     (opcode),
    .alucontrol (alu_sel),
    .funct_ok   (funct_ok)
  );

  always_comb begin
    nxt            = '0;
    branch         = 1'b0;
    nxt.alucontrol = alu_sel;
    case (opcode)
      OP_RTYPE: begin
        nxt.regwrite = funct_ok;
        nxt.regdst   = funct_ok;
      end
      OP_LW: begin
        nxt.regwrite = 1'b1;
        nxt.alusrc   = 1'b1;
        nxt.memtoreg = 1'b1;
      end
      OP_SW: begin
        nxt.memwrite = 1'b1;
        nxt.alusrc   = 1'b1;
      end
      OP_BEQ: branch = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        nxt.regwrite = 1'b1;
        nxt.alusrc   = 1'b1;
      end
      OP_J: nxt.jump = 1'b1;
      default: nxt.alucontrol = ALU_AND;
    endcase
    nxt.pcsrc = branch & zero;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else        q <= nxt;
  end

  assign aluControl = q.alucontrol;
  assign memWrite   = q.memwrite;
  assign regWrite   = q.regwrite;
  assign aluSrc     = q.alusrc;
  assign jump       = q.jump;
  assign memtoReg   = q.memtoreg;
  assign pcsrc      = q.pcsrc;
  assign regdst     = q.regdst;

endmodule

// File: tb/tb_mips_controller.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor pops and checks after each edge.
module tb_mips_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic [3:0] aluControl;
  logic       memWrite, regWrite, aluSrc, jump, memtoReg, pcsrc, regdst;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [10:0] exp;
    int          id;
  } sb_t;
  sb_t sbq[$];

  mips_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .aluControl (aluControl),
    .memWrite   (memWrite),
    .regWrite   (regWrite),
    .aluSrc     (aluSrc),
    .jump       (jump),
    .memtoReg   (memtoReg),
    .pcsrc      (pcsrc),
    .regdst     (regdst)
  );

  always #5 clk = ~clk;

  // Packed as {alu[3:0], memWrite, regWrite, aluSrc, jump, memtoReg, pcsrc, regdst}
  function automatic logic [10:0] model(input logic rst, input logic [5:0] op,
                                        input logic [5:0] fn, input logic z);
    logic [3:0] alu;
    logic mw, rw, as, j, mr, pc, rd;
    alu = 4'd0; mw = 0; rw = 0; as = 0; j = 0; mr = 0; pc = 0; rd = 0;
    if (rst) begin
      case (op)
        6'd0: begin
          case (fn)
            6'd32: begin alu = 4'd2; rw = 1; rd = 1; end
            6'd34: begin alu = 4'd6; rw = 1; rd = 1; end
            6'd36: begin alu = 4'd0; rw = 1; rd = 1; end
            6'd37: begin alu = 4'd1; rw = 1; rd = 1; end
            6'd42: begin alu = 4'd7; rw = 1; rd = 1; end
            default: ;
          endcase
        end
        6'd35: begin alu = 4'd2; rw = 1; as = 1; mr = 1; end
        6'd43: begin alu = 4'd2; mw = 1; as = 1; end
        6'd4:  begin alu = 4'd6; pc = z; end
        6'd8:  begin alu = 4'd2; rw = 1; as = 1; end
        6'd12: begin alu = 4'd0; rw = 1; as = 1; end
        6'd13: begin alu = 4'd1; rw = 1; as = 1; end
        6'd10: begin alu = 4'd7; rw = 1; as = 1; end
        6'd2:  j = 1;
        default: ;
      endcase
    end
    return {alu, mw, rw, as, j, mr, pc, rd};
  endfunction

  int id_cnt = 0;

  task automatic apply(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z);
    sb_t e;
    @(negedge clk);
    rst_n  = r;
    opcode = op;
    funct  = fn;
    zero   = z;
    e.exp  = model(r, op, fn, z);
    e.id   = id_cnt++;
    sbq.push_back(e);
  endtask

  // Monitor: outputs settle right after the edge that sampled the queued stimulus
  initial begin
    sb_t e;
    logic [10:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e   = sbq.pop_front();
        act = {aluControl, memWrite, regWrite, aluSrc, jump, memtoReg, pcsrc, regdst};
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL ctrl#%0d got=%b want=%b", e.id, act, e.exp);
        end
      end
    end
  end

  initial begin
    logic [5:0] ops[10];
    logic [5:0] fns[5];
    logic [5:0] op, fn;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
            6'b001100, 6'b001101, 6'b001010, 6'b000010, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0;

    apply(0, 6'b100011, 6'bx, 0);
    apply(0, 6'b100011, 6'bx, 0);
    apply(1, 6'b100011, 6'bx, 0);
    apply(1, 6'b101011, 6'bx, 1);
    apply(1, 6'b000100, 6'bx, 1);
    apply(1, 6'b000100, 6'bx, 0);
    apply(1, 6'b100011, 6'bx, 1);
    apply(1, 6'b001000, 6'bx, 0);
    apply(1, 6'b001100, 6'bx, 0);
    apply(1, 6'b001101, 6'bx, 0);
    apply(1, 6'b001010, 6'bx, 1);
    for (int i = 0; i < 5; i++) apply(1, 6'b000000, fns[i], i[0]);
    apply(1, 6'b000010, 6'b100000, 1);
    apply(1, 6'b111111, 6'b100000, 1);
    apply(1, 6'b000000, 6'b000000, 0);
    apply(0, 6'b000100, 6'b000000, 1);
    apply(1, 6'b000100, 6'b000000, 1);

    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      apply(($urandom_range(0, 15) != 0), op, fn, 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
